// File: rtl/udp_cmd_responder_if.sv
// udp_cmd_responder_if
//   Groups the Ethernet core's UDP receive stream and UDP transmit port.
//   master : the Ethernet core (drives the receive stream and tx busy,
//            consumes the reply request and reply byte stream)
//   slave  : the responder
//   Receive stream : m_udp_dout, m_udp_valid, m_udp_sof, m_udp_eof,
//                    m_udp_chksum_ok, m_udp_src_ip, m_udp_dst_ip,
//                    m_udp_src_port, m_udp_dst_port
//   Transmit port  : s_udp_tx_busy, s_udp_tx_start, s_udp_tx_len,
//                    s_udp_tx_dat, s_udp_dst_ip, s_udp_dst_port,
//                    s_udp_src_port
interface udp_cmd_responder_if;
    logic [7:0]  m_udp_dout;
    logic        m_udp_valid;
    logic        m_udp_sof;
    logic        m_udp_eof;
    logic        m_udp_chksum_ok;
    logic [31:0] m_udp_src_ip;
    logic [31:0] m_udp_dst_ip;
    logic [15:0] m_udp_src_port;
    logic [15:0] m_udp_dst_port;

    logic        s_udp_tx_busy;
    logic        s_udp_tx_start;
    logic [15:0] s_udp_tx_len;
    logic [7:0]  s_udp_tx_dat;
    logic [31:0] s_udp_dst_ip;
    logic [15:0] s_udp_dst_port;
    logic [15:0] s_udp_src_port;

    modport master (
        output m_udp_dout, m_udp_valid, m_udp_sof, m_udp_eof, m_udp_chksum_ok,
        output m_udp_src_ip, m_udp_dst_ip, m_udp_src_port, m_udp_dst_port,
        output s_udp_tx_busy,
        input  s_udp_tx_start, s_udp_tx_len, s_udp_tx_dat,
        input  s_udp_dst_ip, s_udp_dst_port, s_udp_src_port
    );

    modport slave (
        input  m_udp_dout, m_udp_valid, m_udp_sof, m_udp_eof, m_udp_chksum_ok,
        input  m_udp_src_ip, m_udp_dst_ip, m_udp_src_port, m_udp_dst_port,
        input  s_udp_tx_busy,
        output s_udp_tx_start, s_udp_tx_len, s_udp_tx_dat,
        output s_udp_dst_ip, s_udp_dst_port, s_udp_src_port
    );
endinterface

// File: rtl/udp_cmd_responder.sv
// udp_cmd_responder
//   Captures each checksum-valid datagram addressed to cfg_my_ip:cfg_my_port
//   into a local buffer and answers the sender with REPLY_TAG, the 16-bit
//   accepted-datagram count, and the echoed payload.
//   clk_125m_eth, rst    : Ethernet-domain clock, synchronous active-high reset
//   cfg_my_ip/my_port    : local address; my_port is also the reply source port
//   eth (slave)          : UDP receive stream and UDP transmit port
//   rx_ok_cnt            : accepted datagrams (wraps)
//   drop_cnt             : dropped matching datagrams (saturates)
//   resp_busy            : high whenever the responder is not idle
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | waiting for a matching sof
// S_RECV    | storing payload bytes into the buffer
// S_CHECK   | one cycle: accept (checksum ok, no overflow) or drop
// S_WAIT_TX | waiting for the transmit port to go idle, then pulse start
// S_SEND    | streaming header then buffered payload
// S_DONE    | waiting for the transmit port to finish
module udp_cmd_responder #(
    parameter int          AW        = 11,
    parameter logic [15:0] REPLY_TAG = 16'hA55A
) (
    input  logic               clk_125m_eth,
    input  logic               rst,
    input  logic [31:0]        cfg_my_ip,
    input  logic [15:0]        cfg_my_port,
    udp_cmd_responder_if.slave eth,
    output logic [15:0]        rx_ok_cnt,
    output logic [15:0]        drop_cnt,
    output logic               resp_busy
);
    localparam int DEPTH = 1 << AW;
    localparam int PW    = AW + 1;   // write pointer / length: 0..DEPTH
    localparam int IW    = AW + 2;   // reply byte index: 0..DEPTH+3

    typedef enum logic [2:0] {
        S_IDLE, S_RECV, S_CHECK, S_WAIT_TX, S_SEND, S_DONE
    } state_t;

    state_t        state_q, state_d;

    logic [PW-1:0] wptr_q;
    logic [PW-1:0] len_q;
    logic [IW-1:0] idx_q;
    logic          ovf_q;
    logic          chk_ok_q;
    logic          busy_q;
    logic [15:0]   tx_len_q;
    logic [31:0]   dst_ip_q;
    logic [15:0]   dst_port_q;
    logic [15:0]   src_port_q;

    logic [7:0]    mem [DEPTH];
    logic [7:0]    rdata_q;
    logic [AW-1:0] raddr;

    logic          match;
    logic          capture;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          set_ovf;
    logic          eof_seen;
    logic          accept;
    logic          reject;
    logic          busy_drop;
    logic          tx_go;
    logic          last_byte;
    logic [16:0]   drop_sum;
    logic [7:0]    tx_dat_c;

    assign match = eth.m_udp_sof && eth.m_udp_valid &&
                   (eth.m_udp_dst_port == cfg_my_port) &&
                   (eth.m_udp_dst_ip == cfg_my_ip);

    assign last_byte = (idx_q == (IW'(len_q) + IW'(3)));

    // Payload byte k of the reply is index k+4; the registered RAM read
    // needs its address one cycle earlier, hence idx - 3.
    assign raddr = idx_q[AW-1:0] - AW'(3);

    always_comb begin
        state_d   = state_q;
        capture   = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        set_ovf   = 1'b0;
        eof_seen  = 1'b0;
        accept    = 1'b0;
        reject    = 1'b0;
        busy_drop = 1'b0;
        tx_go     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (match) begin
                    capture = 1'b1;
                    wr_en   = 1'b1;
                    // A 1-byte payload carries sof and eof together.
                    if (eth.m_udp_eof) begin
                        eof_seen = 1'b1;
                        state_d  = S_CHECK;
                    end else begin
                        state_d  = S_RECV;
                    end
                end
            end
            S_RECV: begin
                if (eth.m_udp_valid) begin
                    if (eth.m_udp_sof) begin
                        // Truncated datagram: drop it, do not capture the new one.
                        reject  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        if (wptr_q == PW'(DEPTH)) begin
                            set_ovf = 1'b1;
                        end else begin
                            wr_en   = 1'b1;
                            wr_addr = wptr_q[AW-1:0];
                        end
                        if (eth.m_udp_eof) begin
                            eof_seen = 1'b1;
                            state_d  = S_CHECK;
                        end
                    end
                end
            end
            S_CHECK: begin
                busy_drop = match;
                if (chk_ok_q && !ovf_q) begin
                    accept  = 1'b1;
                    state_d = S_WAIT_TX;
                end else begin
                    reject  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_WAIT_TX: begin
                busy_drop = match;
                // busy_q keeps the start pulse free of any input-to-output path.
                if (!busy_q) begin
                    tx_go   = 1'b1;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                busy_drop = match;
                if (last_byte) state_d = S_DONE;
            end
            S_DONE: begin
                busy_drop = match;
                if (!eth.s_udp_tx_busy) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A busy-drop and a CHECK drop can land in the same cycle.
    assign drop_sum = {1'b0, drop_cnt} + 17'(reject) + 17'(busy_drop);

    always_ff @(posedge clk_125m_eth) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wptr_q     <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            ovf_q      <= 1'b0;
            chk_ok_q   <= 1'b0;
            busy_q     <= 1'b0;
            tx_len_q   <= '0;
            dst_ip_q   <= '0;
            dst_port_q <= '0;
            src_port_q <= '0;
            rx_ok_cnt  <= '0;
            drop_cnt   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= eth.s_udp_tx_busy;

            if (capture) begin
                wptr_q     <= PW'(1);
                ovf_q      <= 1'b0;
                dst_ip_q   <= eth.m_udp_src_ip;
                dst_port_q <= eth.m_udp_src_port;
                src_port_q <= cfg_my_port;
            end else begin
                if (wr_en)   wptr_q <= wptr_q + PW'(1);
                if (set_ovf) ovf_q  <= 1'b1;
            end

            if (eof_seen) chk_ok_q <= eth.m_udp_chksum_ok;

            if (accept) begin
                len_q     <= wptr_q;
                tx_len_q  <= 16'(wptr_q) + 16'd4;
                rx_ok_cnt <= rx_ok_cnt + 16'd1;
            end

            drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

            if (tx_go) begin
                idx_q <= '0;
            end else if (state_q == S_SEND) begin
                idx_q <= idx_q + IW'(1);
            end
        end
    end

    always_ff @(posedge clk_125m_eth) begin
        if (wr_en) mem[wr_addr] <= eth.m_udp_dout;
        rdata_q <= mem[raddr];
    end

    always_comb begin
        tx_dat_c = 8'h00;
        if (state_q == S_SEND) begin
            case (idx_q)
                IW'(0):  tx_dat_c = REPLY_TAG[15:8];
                IW'(1):  tx_dat_c = REPLY_TAG[7:0];
                IW'(2):  tx_dat_c = rx_ok_cnt[15:8];
                IW'(3):  tx_dat_c = rx_ok_cnt[7:0];
                default: tx_dat_c = rdata_q;
            endcase
        end
    end

    assign eth.s_udp_tx_start = tx_go;
    assign eth.s_udp_tx_len   = tx_len_q;
    assign eth.s_udp_tx_dat   = tx_dat_c;
    assign eth.s_udp_dst_ip   = dst_ip_q;
    assign eth.s_udp_dst_port = dst_port_q;
    assign eth.s_udp_src_port = src_port_q;
    assign resp_busy          = (state_q != S_IDLE);
endmodule

// File: tb/tb_udp_cmd_responder.sv
// tb_udp_cmd_responder
//   Self-checking bench for udp_cmd_responder: a table of directed datagrams,
//   randomized datagrams predicted from the reply rules, and hand-written
//   multi-cycle corner cases (busy-drop during SEND, sof inside RECV,
//   reset mid-capture).
module tb_udp_cmd_responder;
    localparam logic [31:0] MY_IP   = 32'hC0A8_010A;
    localparam logic [15:0] MY_PORT = 16'd7777;

    logic        clk_125m_eth = 1'b0;
    logic        rst;
    logic [31:0] cfg_my_ip   = MY_IP;
    logic [15:0] cfg_my_port = MY_PORT;
    logic [15:0] rx_ok_cnt;
    logic [15:0] drop_cnt;
    logic        resp_busy;

    udp_cmd_responder_if eth();

    udp_cmd_responder #(.AW(11), .REPLY_TAG(16'hA55A)) dut (
        .clk_125m_eth (clk_125m_eth),
        .rst          (rst),
        .cfg_my_ip    (cfg_my_ip),
        .cfg_my_port  (cfg_my_port),
        .eth          (eth),
        .rx_ok_cnt    (rx_ok_cnt),
        .drop_cnt     (drop_cnt),
        .resp_busy    (resp_busy)
    );

    always #4 clk_125m_eth = ~clk_125m_eth;

    int checks   = 0;
    int failures = 0;
    int model_rx   = 0;
    int model_drop = 0;
    int eof_cyc    = 0;

    logic [7:0] pay   [0:2048];
    logic [7:0] exp_b [0:2055];

    // ---------------- transmit-port monitor ----------------
    int cyc = 0;
    always @(posedge clk_125m_eth) cyc <= cyc + 1;

    int          starts = 0, replies_done = 0, start_cyc = 0;
    int          remaining = 0, cap_n = 0, dat_idle_err = 0;
    logic [15:0] cap_len, cap_dport, cap_sport;
    logic [31:0] cap_ip;
    logic [7:0]  cap [0:2055];

    always @(negedge clk_125m_eth) begin
        if (rst) begin
            remaining <= 0;
        end else if (eth.s_udp_tx_start) begin
            starts    <= starts + 1;
            start_cyc <= cyc;
            cap_len   <= eth.s_udp_tx_len;
            cap_ip    <= eth.s_udp_dst_ip;
            cap_dport <= eth.s_udp_dst_port;
            cap_sport <= eth.s_udp_src_port;
            remaining <= int'(eth.s_udp_tx_len);
            cap_n     <= 0;
            if (eth.s_udp_tx_dat != 8'h00) dat_idle_err <= dat_idle_err + 1;
        end else if (remaining > 0) begin
            if (cap_n < 2056) cap[cap_n] <= eth.s_udp_tx_dat;
            cap_n     <= cap_n + 1;
            remaining <= remaining - 1;
            if (remaining == 1) replies_done <= replies_done + 1;
        end else if (eth.s_udp_tx_dat != 8'h00) begin
            dat_idle_err <= dat_idle_err + 1;
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_125m_eth);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        eth.m_udp_valid = 1'b0;
        eth.m_udp_sof = 1'b0;
        eth.m_udp_eof = 1'b0;
        eth.m_udp_chksum_ok = 1'b0;
        repeat (n) step();
    endtask

    task automatic drive_byte(input logic [7:0] d, input logic sof, input logic eof, input logic ck);
        eth.m_udp_dout      = d;
        eth.m_udp_valid     = 1'b1;
        eth.m_udp_sof       = sof;
        eth.m_udp_eof       = eof;
        eth.m_udp_chksum_ok = eof ? ck : 1'b0;
        step();
    endtask

    task automatic set_hdr(input logic [31:0] dip, input logic [15:0] dport,
                           input logic [31:0] sip, input logic [15:0] sport);
        eth.m_udp_dst_ip   = dip;
        eth.m_udp_dst_port = dport;
        eth.m_udp_src_ip   = sip;
        eth.m_udp_src_port = sport;
    endtask

    // Drives a whole datagram with random payload; leaves valid low one
    // cycle after the eof byte.
    task automatic drive_dg(input int plen, input logic [31:0] dip, input logic [15:0] dport,
                            input logic ck, input logic [31:0] sip, input logic [15:0] sport);
        set_hdr(dip, dport, sip, sport);
        for (int i = 0; i < plen; i++) begin
            pay[i] = 8'($urandom);
            if (i == plen - 1) eof_cyc = cyc;
            drive_byte(pay[i], i == 0, i == plen - 1, ck);
        end
        eth.m_udp_valid = 1'b0;
        eth.m_udp_sof = 1'b0;
        eth.m_udp_eof = 1'b0;
        eth.m_udp_chksum_ok = 1'b0;
    endtask

    task automatic build_exp(input int plen, input logic [15:0] cnt);
        exp_b[0] = 8'hA5;
        exp_b[1] = 8'h5A;
        exp_b[2] = cnt[15:8];
        exp_b[3] = cnt[7:0];
        for (int i = 0; i < plen; i++) exp_b[4 + i] = pay[i];
    endtask

    task automatic cmp_reply(input string name, input int plen, input logic [31:0] sip,
                             input logic [15:0] sport);
        int bad;
        bad = -1;
        chk({name, " tx_len"}, cap_len, 64'(plen + 4));
        chk({name, " dst_ip"}, cap_ip, sip);
        chk({name, " dst_port"}, cap_dport, sport);
        chk({name, " src_port"}, cap_sport, MY_PORT);
        for (int i = 0; i < plen + 4; i++)
            if (bad < 0 && cap[i] !== exp_b[i]) bad = i;
        chk({name, " first_bad_byte_idx"}, 64'(bad), 64'(-1));
    endtask

    task automatic wait_replies(input int target, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            if (replies_done >= target) ok = 1'b1;
            else step();
        end
    endtask

    task automatic wait_starts(input int target, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            if (starts >= target) ok = 1'b1;
            else step();
        end
    endtask

    task automatic wait_idle(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            if (!resp_busy) ok = 1'b1;
            else step();
        end
    endtask

    task automatic run_vec(input string name, input int plen, input bit ip_ok, input bit port_ok,
                           input bit ck, input int hold, input bit exp_reply, input bit exp_drop);
        logic [31:0] sip, dip;
        logic [15:0] sport, dport;
        int st0, rd0, n;
        bit ok;
        sip   = $urandom;
        sport = 16'($urandom);
        dip   = ip_ok   ? MY_IP   : (MY_IP   ^ (32'd1 << $urandom_range(31, 0)));
        dport = port_ok ? MY_PORT : (MY_PORT ^ (16'd1 << $urandom_range(15, 0)));
        st0 = starts;
        rd0 = replies_done;
        drive_dg(plen, dip, dport, ck, sip, sport);
        n = eof_cyc;
        if (exp_reply) begin
            model_rx = (model_rx + 1) % 65536;
            build_exp(plen, 16'(model_rx));
        end
        if (exp_drop && model_drop < 65535) model_drop++;
        if (hold > 0) begin
            eth.s_udp_tx_busy = 1'b1;
            repeat (hold) step();
            eth.s_udp_tx_busy = 1'b0;
        end
        if (exp_reply) begin
            wait_replies(rd0 + 1, plen + hold + 64, ok);
            chk({name, " reply_seen"}, ok, 1);
            if (ok) begin
                chk({name, " start_cycle"}, start_cyc, n + 2 + hold);
                cmp_reply(name, plen, sip, sport);
            end
            wait_idle(16, ok);
            chk({name, " back_to_idle"}, ok, 1);
        end else begin
            if (hold == 0) step();
            chk({name, " resp_busy_low"}, resp_busy, 0);
            idle_cycles(6);
            chk({name, " no_start"}, starts, st0);
        end
        chk({name, " rx_ok_cnt"}, rx_ok_cnt, model_rx);
        chk({name, " drop_cnt"}, drop_cnt, model_drop);
        idle_cycles(2);
    endtask

    typedef struct {
        int plen;
        bit ip_ok;
        bit port_ok;
        bit ck;
        int hold;
        bit exp_reply;
        bit exp_drop;
    } vec_t;

    vec_t vt [11];

    initial begin
        int st0, rd0;
        bit ok;
        logic [31:0] sip;
        logic [15:0] sport;

        //      plen  ip port ck hold reply drop
        vt[0]  = '{8,    1, 1, 1, 0,  1, 0};
        vt[1]  = '{8,    1, 1, 0, 0,  0, 1};
        vt[2]  = '{1,    1, 1, 1, 0,  1, 0};
        vt[3]  = '{8,    0, 1, 1, 0,  0, 0};
        vt[4]  = '{6,    1, 1, 1, 0,  1, 0};
        vt[5]  = '{8,    1, 0, 1, 0,  0, 0};
        vt[6]  = '{4,    1, 1, 1, 51, 1, 0};
        vt[7]  = '{2049, 1, 1, 1, 0,  0, 1};
        vt[8]  = '{4,    1, 1, 1, 0,  1, 0};
        vt[9]  = '{2048, 1, 1, 1, 0,  1, 0};
        vt[10] = '{16,   1, 1, 1, 3,  1, 0};

        rst = 1'b1;
        eth.m_udp_dout = 8'h00;
        eth.s_udp_tx_busy = 1'b0;
        set_hdr(32'h0, 16'h0, 32'h0, 16'h0);
        idle_cycles(4);
        rst = 1'b0;
        step();

        chk("reset tx_start", eth.s_udp_tx_start, 0);
        chk("reset tx_len", eth.s_udp_tx_len, 0);
        chk("reset tx_dat", eth.s_udp_tx_dat, 0);
        chk("reset dst_ip", eth.s_udp_dst_ip, 0);
        chk("reset dst_port", eth.s_udp_dst_port, 0);
        chk("reset src_port", eth.s_udp_src_port, 0);
        chk("reset rx_ok_cnt", rx_ok_cnt, 0);
        chk("reset drop_cnt", drop_cnt, 0);
        chk("reset resp_busy", resp_busy, 0);

        for (int i = 0; i < 11; i++)
            run_vec($sformatf("vec%0d", i), vt[i].plen, vt[i].ip_ok, vt[i].port_ok,
                    vt[i].ck, vt[i].hold, vt[i].exp_reply, vt[i].exp_drop);

        // Randomized datagrams; expectation follows the accept/drop rules.
        for (int i = 0; i < 24; i++) begin
            int  plen, hold;
            bit  ip_ok, port_ok, ck, er, ed;
            plen    = $urandom_range(64, 1);
            ip_ok   = ($urandom % 4) != 0;
            port_ok = ($urandom % 4) != 0;
            ck      = ($urandom % 5) != 0;
            hold    = (($urandom % 3) == 0) ? $urandom_range(10, 1) : 0;
            er      = ip_ok && port_ok && ck && (plen <= 2048);
            ed      = ip_ok && port_ok && !er;
            run_vec($sformatf("rand%0d", i), plen, ip_ok, port_ok, ck, hold, er, ed);
        end

        // Matching datagram arriving during SEND of a 30-byte reply.
        st0 = starts;
        rd0 = replies_done;
        sip = $urandom;
        sport = 16'($urandom);
        drive_dg(30, MY_IP, MY_PORT, 1'b1, sip, sport);
        model_rx = (model_rx + 1) % 65536;
        build_exp(30, 16'(model_rx));
        wait_starts(st0 + 1, 12, ok);
        chk("busydrop start_seen", ok, 1);
        idle_cycles(3);
        drive_dg(3, MY_IP, MY_PORT, 1'b1, 32'h0A00_0001, 16'd1234);
        model_drop++;
        wait_replies(rd0 + 1, 100, ok);
        chk("busydrop reply_seen", ok, 1);
        if (ok) cmp_reply("busydrop", 30, sip, sport);
        wait_idle(16, ok);
        idle_cycles(6);
        chk("busydrop single_start", starts, st0 + 1);
        chk("busydrop rx_ok_cnt", rx_ok_cnt, model_rx);
        chk("busydrop drop_cnt", drop_cnt, model_drop);

        // New sof inside RECV: one drop, nothing captured.
        st0 = starts;
        set_hdr(MY_IP, MY_PORT, 32'h0A00_0002, 16'd4321);
        drive_byte(8'h11, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_byte(8'(i), 1'b0, 1'b0, 1'b0);
        drive_byte(8'h22, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_byte(8'(i + 8), 1'b0, i == 3, 1'b1);
        model_drop++;
        idle_cycles(10);
        chk("sof_in_recv no_start", starts, st0);
        chk("sof_in_recv resp_busy", resp_busy, 0);
        chk("sof_in_recv rx_ok_cnt", rx_ok_cnt, model_rx);
        chk("sof_in_recv drop_cnt", drop_cnt, model_drop);

        // Reset mid-capture, then a fresh datagram replies with count 1.
        set_hdr(MY_IP, MY_PORT, 32'h0A00_0003, 16'd999);
        drive_byte(8'h33, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive_byte(8'h44, 1'b0, 1'b0, 1'b0);
        eth.m_udp_valid = 1'b0;
        eth.m_udp_sof = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_rx = 0;
        model_drop = 0;
        chk("midrst resp_busy", resp_busy, 0);
        chk("midrst rx_ok_cnt", rx_ok_cnt, 0);
        chk("midrst drop_cnt", drop_cnt, 0);
        chk("midrst tx_len", eth.s_udp_tx_len, 0);
        chk("midrst dst_ip", eth.s_udp_dst_ip, 0);
        idle_cycles(2);
        run_vec("post_rst", 4, 1, 1, 1, 0, 1, 0);

        chk("tx_dat_zero_outside_send", dat_idle_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
